dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port.
- Accepts one load/store request at a time over a valid/ready handshake.
- Performs byte-lane alignment (strobe generation, write-data shift, read-data extract).
- Returns a response after a fixed, programmable latency, held until the core accepts it.
- Replaces the ideal single-cycle data memory so the pipeline can be exercised against realistic, back-pressured memory timing.

Parameters:
- ADDR_W, 14: byte-address width; word index is req_addr[ADDR_W-1:2].
- DEPTH, 4096: number of 32-bit words; must equal 2**(ADDR_W-2).
- LATENCY, 2: cycles from the acceptance edge to rsp_valid rising; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  ADDR_W  byte address.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load data, right-aligned and zero-extended; sign extension stays in the core. 0 for stores.
- rsp_err  output  1  request faulted.

Behaviour:
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
- Memory array is not cleared by reset.
- States:
  - IDLE: req_ready = 1.
  - WAIT: req_ready = 0, counting down.
  - RESP: rsp_valid = 1, req_ready = 0.
- Acceptance = req_valid & req_ready at a rising edge. On that same edge:
  - store: write mem[word] with strobes (size_mask << off) and data (req_wdata << 8*off). size_mask is 0001 / 0011 / 1111; off = req_addr[1:0].
  - load: register (mem[word] >> 8*off), masked to 8 bits (byte), 16 bits (half) or 32 bits (word).
  - store response data is 0.
- Transitions:
  - IDLE → WAIT on acceptance, counter loaded with LATENCY-1.
  - If LATENCY = 1, IDLE → RESP directly.
  - WAIT decrements each cycle; WAIT → RESP when the counter reaches 0.
  - rsp_valid is high exactly LATENCY cycles after the acceptance edge.
- RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_valid & rsp_ready, then → IDLE.
  - req_ready returns high the cycle after the handshake.
  - No same-cycle response/request overlap; minimum period is LATENCY+1 cycles per access.
- req_valid while not ready: ignored, no side effects. The requester must hold its request.
- Read-after-write to the same word in the next access returns the new data.
- Fault conditions: req_size = 3; half with off[0] = 1; word with off != 0. On a fault:
  - no write;
  - rsp_rdata = 0, rsp_err = 1;
  - same latency as a normal access.
- Reset asserted mid-WAIT or mid-RESP: immediately returns to IDLE with reset values; any pending response is dropped. A store accepted before reset stays committed.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- Defined: faults detected as above; rsp_err driven.
- Undefined:
  - rsp_err tied 0.
  - Offset bits below the access size are forced to 0 (half uses off & 2'b10; word uses 2'b00).
  - req_size = 3 treated as word.
  - The access always completes.

Test Plan:
- Store word 0xDEADBEEF at addr 0x010, then load word 0x010 (LATENCY = 2) → rsp_valid exactly 2 cycles after each acceptance; load rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Then store byte 0xA5 at 0x013; load word 0x010 → 0xA5ADBEEF. Load byte 0x013 → 0x000000A5. Load half 0x012 → 0x0000A5AD.
- Hold rsp_ready = 0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable, req_ready = 0 throughout. Extra req_valid pulses cause no writes. Raise rsp_ready → IDLE, req_ready = 1 next cycle.
- With macro defined, store half 0x1234 at 0x021 (word at 0x020 preloaded 0x11111111) → rsp_err = 1, word 0x020 still 0x11111111. With macro undefined, same stimulus → rsp_err = 0, word 0x020 = 0x11111234.
- Drive reset low during WAIT of a load → rsp_valid = 0, req_ready = 1 immediately. After release, a new load completes normally with correct data.
- LATENCY = 1 build, back-to-back loads with rsp_ready = 1 → rsp_valid one cycle after each acceptance; one access per 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with byte-lane alignment and a fixed, programmable response latency.
// Optional macro DMEM_MISALIGN_CHECK_EN: flag misaligned/illegal accesses on rsp_err instead of forcing alignment.
module dmem_responder #(
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              wr_en;
  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        off;
  logic [1:0]        eff_off;
  logic [1:0]        eff_size;
  logic              fault;
  logic [3:0]        size_mask;
  logic [3:0]        strobe;
  logic [31:0]       lane_mask;
  logic [31:0]       wdata_sh;
  logic [31:0]       mem_word;
  logic [31:0]       rdata_al;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept   = req_valid & req_ready;
  assign word_idx = req_addr[ADDR_W-1:2];
  assign off      = req_addr[1:0];
  assign wr_en    = accept & req_we & ~fault;

  always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
    eff_size = req_size;
    eff_off  = off;
    fault    = (req_size == 2'd3)
             | ((req_size == 2'd1) & off[0])
             | ((req_size == 2'd2) & (off != 2'd0));
`else
    // Without the check, drop offset bits below the access size so every access completes.
    eff_size = (req_size == 2'd3) ? 2'd2 : req_size;
    fault    = 1'b0;
    case (eff_size)
      2'd0:    eff_off = off;
      2'd1:    eff_off = off & 2'b10;
      default: eff_off = 2'b00;
    endcase
`endif
  end

  always_comb begin
    case (eff_size)
      2'd0: begin
        size_mask = 4'b0001;
        lane_mask = 32'h0000_00FF;
      end
      2'd1: begin
        size_mask = 4'b0011;
        lane_mask = 32'h0000_FFFF;
      end
      default: begin
        size_mask = 4'b1111;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign strobe   = size_mask << eff_off;
  assign wdata_sh = req_wdata << {eff_off, 3'b000};
  assign mem_word = mem[word_idx];
  assign rdata_al = (mem_word >> {eff_off, 3'b000}) & lane_mask;

  // Storage is intentionally outside the reset domain; a committed store survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = (req_we || fault) ? 32'd0 : rdata_al;
          err_d   = fault;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        // Leaving when the count hits zero puts rsp_valid exactly LATENCY edges after acceptance.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
